// File: rtl/alu_serial_exec_if.sv
// Request/response bundle between the core pipeline and alu_serial_exec.
// The master issues operations and consumes results; the slave is the execute unit.
interface alu_serial_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, bit-serial shifts
// (one bit per cycle), valid/ready handshake on request and result sides.
module alu_serial_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_serial_exec_if.slave  bus
);
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b11
  } shkind_t;

  state_t                state;
  shkind_t               shkind;
  logic [DATA_WIDTH-1:0] acc;
  logic [SHW-1:0]        cnt;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  in_ready_r;
  logic                  out_valid_r;

  logic [DATA_WIDTH-1:0] acc_step;
  logic [SHW-1:0]        shamt;
  logic                  is_shift;

  function automatic logic [DATA_WIDTH-1:0] alu_comb(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [DATA_WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1100: r = (sa < sb) ? DATA_WIDTH'(1) : '0;
      4'b1000: r = (a == b) ? DATA_WIDTH'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift1(
    input shkind_t               k,
    input logic [DATA_WIDTH-1:0] v
  );
    logic [DATA_WIDTH-1:0] r;
    case (k)
      SH_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
      SH_SRA:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: r = {1'b0, v[DATA_WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign shamt    = bus.SrcB[SHW-1:0];
  assign is_shift = (bus.Operation == 4'b0100) || (bus.Operation == 4'b0101) ||
                    (bus.Operation == 4'b0111);
  assign acc_step = shift1(shkind, acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      shkind      <= SH_SLL;
      acc         <= '0;
      cnt         <= '0;
      result      <= '0;
      zero        <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (is_shift) begin
              acc    <= bus.SrcA;
              cnt    <= shamt;
              shkind <= shkind_t'(bus.Operation[1:0]);
              if (shamt == '0) begin
                result      <= bus.SrcA;
                zero        <= (bus.SrcA == '0);
                out_valid_r <= 1'b1;
                state       <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              result      <= alu_comb(bus.Operation, bus.SrcA, bus.SrcB);
              zero        <= (alu_comb(bus.Operation, bus.SrcA, bus.SrcB) == '0);
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - SHW'(1);
          // Last step: publish the shifted word directly so DONE follows immediately.
          if (cnt == SHW'(1)) begin
            result      <= acc_step;
            zero        <= (acc_step == '0);
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.ALUResult = result;
  assign bus.Zero      = zero;

endmodule
